sparse_pos_packer: RTL and testbench
====================================

// Module: sparse_pos_packer
// PURPOSE
//  Upstream stage of the sparse multiplier (sparse_mul_*). Accepts the H non-zero secret
//  positions as a stream, one per cycle, under a valid/ready handshake.
//  Packs CORE_NUM positions per word and writes the words into the multiplier's position RAM.
//  Then pulses the multiplier start, waits for its done, and reports completion.
// PARAMETERS
//  N          1024  polynomial length; POS_WIDTH = $clog2(N)
//  H          384   number of positions per session
//  CORE_NUM   8     lanes per position-RAM word; POS_RAM_WIDTH = POS_WIDTH*CORE_NUM
//  PAD_POS    0     value written into unused lanes of a final partial word
//  POS_RAM_DEPTH    derived = (H+CORE_NUM-1)/CORE_NUM; ADDR_W = $clog2(POS_RAM_DEPTH)
// PORTS
//  clk              in   1              clock, rising edge
//  rst_n            in   1              asynchronous, active-low reset
//  i_load           in   1              start a session (sampled in IDLE only)
//  s_pos_valid      in   1              position stream valid
//  s_pos_ready      out  1              position stream ready
//  s_pos_data       in   POS_WIDTH      position index, 0..N-1
//  ram_pos_wr_en    out  1              position RAM write enable
//  ram_pos_wr_addr  out  ADDR_W         position RAM word address
//  ram_pos_data_in  out  POS_RAM_WIDTH  packed word; lane k = bits [POS_WIDTH*(k+1)-1 -: POS_WIDTH]
//  mul_start        out  1              one-cycle start pulse to the multiplier
//  mul_done         in   1              multiplier done (sampled in WAIT_MUL only)
//  o_busy           out  1              high in every state except IDLE
//  o_done           out  1              one-cycle pulse at session end
// BEHAVIOUR
//  Reset: all outputs are 0, the lane buffer and counters are cleared, and state = IDLE.
//   Reset is asynchronous and takes effect in any state; a session in progress is abandoned.
//   Position RAM contents written before the reset are then don't-care.
//  Handshake: a transfer occurs at a rising edge where s_pos_valid && s_pos_ready.
//   s_pos_ready = (state==COLLECT). It is combinational from state only, never from valid.
//  FSM:
//   IDLE -> COLLECT when i_load=1. The position count, lane index and word address reset to 0.
//   COLLECT: each transfer stores s_pos_data in lane lane_idx, and lane_idx increments.
//    - On the transfer that fills lane CORE_NUM-1, the completed word is registered into
//      ram_pos_data_in, including the incoming position. ram_pos_wr_en=1 for exactly one
//      cycle, the next cycle, with ram_pos_wr_addr = current word address.
//    - The word address then increments. The lane buffer clears, so sustained 1 pos/cycle
//      is accepted with no bubbles.
//    - On the H-th transfer, the state goes to FLUSH and ready drops.
//    - If the last word is partial, lanes lane_idx..CORE_NUM-1 are filled with PAD_POS and
//      the word is written with the same one-cycle-later timing.
//   FLUSH: one cycle. It is the cycle in which the final write (wr_en=1) is presented.
//    Next state is START.
//   START: mul_start=1 for exactly one cycle, 2 cycles after the edge that accepted the
//    H-th position. Next state is WAIT_MUL.
//   WAIT_MUL: hold until mul_done=1 is sampled at an edge (level or pulse accepted).
//    Next state is DONE.
//   DONE: o_done=1 for one cycle, then back to IDLE.
//  Exactly POS_RAM_DEPTH writes per session, at addresses 0..POS_RAM_DEPTH-1 in order, no repeats.
//  Ignored inputs:
//   - i_load outside IDLE.
//   - mul_done outside WAIT_MUL.
//   - s_pos_valid while ready=0 (data is not consumed).
//  s_pos_data is stored unmodified. No range check is made, because POS_WIDTH bits cover 0..N-1.
//  Ordering and sign semantics are the producer's and multiplier's concern.
// TESTING
//  T1 reset: drive rst_n=0 mid-cycle -> all outputs 0 immediately; after release, o_busy=0
//     and s_pos_ready=0.
//  T2 defaults, i_load then positions 1..384 back-to-back ->
//     - 48 writes, at addr 0..47;
//     - word i lane k = 8i+k+1;
//     - mul_start 2 cycles after the last accept.
//  T3 same data with random valid gaps (0-5 cycles) -> RAM image identical to T2 and
//     exactly 48 write pulses.
//  T4 H=20, CORE_NUM=8, PAD_POS=1023, positions 100..119 -> 3 writes; word 2 lanes 0-3 =
//     116..119, lanes 4-7 = 1023.
//  T5 hold mul_done=0 for 100 cycles, and pulse i_load and mul_done early during COLLECT ->
//     both early pulses ignored. Then one mul_done pulse -> o_done one cycle later;
//     o_busy falls with state IDLE.
//  T6 assert rst_n=0 after 13 accepts -> ready and wr_en drop. A new session restarts at
//     addr 0 and its RAM image matches T2.

Source files
------------

// File: rtl/sparse_pos_packer_if.sv
// Position stream handshake between producer and packer.
// Transfer on a rising edge with s_pos_valid && s_pos_ready.
interface sparse_pos_packer_if #(
  parameter int POS_WIDTH = 10
);
  logic                 s_pos_valid;
  logic                 s_pos_ready;
  logic [POS_WIDTH-1:0] s_pos_data;

  modport master (
    output s_pos_valid,
    output s_pos_data,
    input  s_pos_ready
  );

  modport slave (
    input  s_pos_valid,
    input  s_pos_data,
    output s_pos_ready
  );
endinterface

// File: rtl/sparse_pos_packer.sv
// Packs streamed secret positions into position-RAM words,
// then kicks the sparse multiplier and waits for it.
module sparse_pos_packer #(
  parameter int N        = 1024,
  parameter int H        = 384,
  parameter int CORE_NUM = 8,
  parameter int PAD_POS  = 0,
  localparam int POS_WIDTH     = $clog2(N),
  localparam int POS_RAM_WIDTH = POS_WIDTH * CORE_NUM,
  localparam int POS_RAM_DEPTH = (H + CORE_NUM - 1) / CORE_NUM,
  localparam int ADDR_W =
    (POS_RAM_DEPTH > 1) ? $clog2(POS_RAM_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  sparse_pos_packer_if.slave       s_pos,
  output logic                     ram_pos_wr_en,
  output logic [ADDR_W-1:0]        ram_pos_wr_addr,
  output logic [POS_RAM_WIDTH-1:0] ram_pos_data_in,
  output logic                     mul_start,
  input  logic                     mul_done,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int LW = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    FLUSH,
    START,
    WAIT_MUL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [POS_WIDTH-1:0] lane_buf [CORE_NUM];
  logic [LW-1:0]        lane_idx;
  logic [CW-1:0]        pos_cnt;
  logic [ADDR_W-1:0]    word_addr;

  logic                     ready;
  logic                     xfer;
  logic                     last_lane;
  logic                     last_pos;
  logic                     wr_now;
  logic [POS_RAM_WIDTH-1:0] word_nx;

  assign s_pos.s_pos_ready = ready;
  assign xfer      = s_pos.s_pos_valid && ready;
  assign last_lane = (lane_idx == LW'(CORE_NUM - 1));
  assign last_pos  = (pos_cnt == CW'(H - 1));
  assign wr_now    = xfer && (last_lane || last_pos);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    mul_start = 1'b0;
    o_busy    = 1'b1;
    o_done    = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_load) state_nx = COLLECT;
      end
      COLLECT: begin
        ready = 1'b1;
        if (xfer && last_pos) state_nx = FLUSH;
      end
      FLUSH: state_nx = START;
      START: begin
        mul_start = 1'b1;
        state_nx  = WAIT_MUL;
      end
      WAIT_MUL: if (mul_done) state_nx = DONE;
      DONE: begin
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word image: buffered lanes, incoming lane, pad above
  always_comb begin
    word_nx = '0;
    for (int k = 0; k < CORE_NUM; k++) begin
      if (LW'(k) < lane_idx)
        word_nx[POS_WIDTH*k +: POS_WIDTH] = lane_buf[k];
      else if (LW'(k) == lane_idx)
        word_nx[POS_WIDTH*k +: POS_WIDTH] = s_pos.s_pos_data;
      else
        word_nx[POS_WIDTH*k +: POS_WIDTH] = POS_WIDTH'(PAD_POS);
    end
  end

  // Lane buffer, counters and registered RAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CORE_NUM; k++) lane_buf[k] <= '0;
      lane_idx        <= '0;
      pos_cnt         <= '0;
      word_addr       <= '0;
      ram_pos_wr_en   <= 1'b0;
      ram_pos_wr_addr <= '0;
      ram_pos_data_in <= '0;
    end else begin
      ram_pos_wr_en <= 1'b0;
      if (state == IDLE && i_load) begin
        for (int k = 0; k < CORE_NUM; k++) lane_buf[k] <= '0;
        lane_idx  <= '0;
        pos_cnt   <= '0;
        word_addr <= '0;
      end else if (xfer) begin
        pos_cnt <= pos_cnt + CW'(1);
        if (wr_now) begin
          ram_pos_wr_en   <= 1'b1;
          ram_pos_wr_addr <= word_addr;
          ram_pos_data_in <= word_nx;
          word_addr       <= word_addr + ADDR_W'(1);
          lane_idx        <= '0;
          for (int k = 0; k < CORE_NUM; k++) lane_buf[k] <= '0;
        end else begin
          lane_buf[lane_idx] <= s_pos.s_pos_data;
          lane_idx           <= lane_idx + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_pos_packer.sv
// Directed bench for sparse_pos_packer: default build plus
// a small H=20 build with a non-zero pad value.
module tb_sparse_pos_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       sel = 1'b0;
  logic       tv = 1'b0;
  logic [9:0] tdata = '0;
  logic       tload = 1'b0;
  logic       tdone = 1'b0;

  sparse_pos_packer_if #(.POS_WIDTH(10)) ifa ();
  sparse_pos_packer_if #(.POS_WIDTH(10)) ifb ();

  assign ifa.s_pos_valid = tv && !sel;
  assign ifa.s_pos_data  = tdata;
  assign ifb.s_pos_valid = tv && sel;
  assign ifb.s_pos_data  = tdata;

  logic        wr_a, wr_b, st_a, st_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [5:0]  addr_a;
  logic [1:0]  addr_b;
  logic [79:0] data_a, data_b;

  sparse_pos_packer dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_load(tload && !sel),
    .s_pos(ifa),
    .ram_pos_wr_en(wr_a),
    .ram_pos_wr_addr(addr_a),
    .ram_pos_data_in(data_a),
    .mul_start(st_a),
    .mul_done(tdone && !sel),
    .o_busy(busy_a),
    .o_done(done_a)
  );

  sparse_pos_packer #(
    .N(1024), .H(20), .CORE_NUM(8), .PAD_POS(1023)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_load(tload && sel),
    .s_pos(ifb),
    .ram_pos_wr_en(wr_b),
    .ram_pos_wr_addr(addr_b),
    .ram_pos_data_in(data_b),
    .mul_start(st_b),
    .mul_done(tdone && sel),
    .o_busy(busy_b),
    .o_done(done_b)
  );

  logic        m_wr, m_start, m_busy, m_done, m_ready;
  logic [5:0]  m_addr;
  logic [79:0] m_data;
  assign m_wr    = sel ? wr_b : wr_a;
  assign m_addr  = sel ? {4'b0, addr_b} : addr_a;
  assign m_data  = sel ? data_b : data_a;
  assign m_start = sel ? st_b : st_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_ready = sel ? ifb.s_pos_ready
                       : ifa.s_pos_ready;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_edge = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int last_w0 = 0;
  int          log_addr [512];
  logic [79:0] log_data [512];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_wr) begin
      if (wr_cnt < 512) begin
        log_addr[wr_cnt] = int'(m_addr);
        log_data[wr_cnt] = m_data;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (m_start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end
    if (m_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string name;
    int    sel;
    int    base;
    int    count;
    int    maxgap;
    int    early;
    int    hold;
    int    pad;
    int    exp_wr;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] exp_word(
    input int base, input int count,
    input int pad, input int i);
    logic [79:0] w;
    int p, v;
    w = '0;
    for (int k = 0; k < 8; k++) begin
      p = 8 * i + k;
      v = (p < count) ? base + p : pad;
      w[10*k +: 10] = v[9:0];
    end
    return w;
  endfunction

  task automatic send(input int base, input int count,
                      input int maxgap, input int early);
    int  gap, n;
    bit  acc;
    for (int i = 0; i < count; i++) begin
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      if (gap > 0) begin
        tv = 1'b0;
        repeat (gap) step();
      end
      tv    = 1'b1;
      tdata = 10'(base + i);
      if (early != 0 && i == 5) begin
        tload = 1'b1;
        tdone = 1'b1;
      end
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
        @(negedge clk);
        acc = m_ready;
        if (acc) acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        n++;
      end
      tload = 1'b0;
      tdone = 1'b0;
      chk("accept_timeout", 128'(acc), 128'(1));
    end
    tv = 1'b0;
  endtask

  task automatic run_session(input vec_t v);
    int w0, s0, d0, n, nw;
    sel = v.sel[0];
    step();
    w0 = wr_cnt;
    s0 = start_cnt;
    d0 = done_cnt;
    last_w0 = w0;
    tload = 1'b1;
    step();
    tload = 1'b0;
    chk({v.name, "_busy_load"}, 128'(m_busy), 128'(1));
    chk({v.name, "_ready_load"}, 128'(m_ready), 128'(1));
    send(v.base, v.count, v.maxgap, v.early);
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      step();
      n++;
    end
    chk({v.name, "_start_cnt"}, 128'(start_cnt - s0), 128'(1));
    chk({v.name, "_start_lat"},
        128'(start_cyc - acc_edge + 1), 128'(2));
    if (v.hold > 0) begin
      repeat (v.hold) step();
      chk({v.name, "_hold_busy"}, 128'(m_busy), 128'(1));
      chk({v.name, "_hold_nodone"}, 128'(done_cnt - d0), 128'(0));
    end
    tdone = 1'b1;
    step();
    tdone = 1'b0;
    chk({v.name, "_o_done"}, 128'(m_done), 128'(1));
    chk({v.name, "_busy_done"}, 128'(m_busy), 128'(1));
    step();
    chk({v.name, "_done_clr"}, 128'(m_done), 128'(0));
    chk({v.name, "_idle"}, 128'(m_busy), 128'(0));
    chk({v.name, "_done_cnt"}, 128'(done_cnt - d0), 128'(1));
    nw = wr_cnt - w0;
    chk({v.name, "_writes"}, 128'(nw), 128'(v.exp_wr));
    for (int i = 0; i < nw && i < v.exp_wr; i++) begin
      chk({v.name, "_addr"}, 128'(log_addr[w0+i]), 128'(i));
      chk({v.name, "_word"}, 128'(log_data[w0+i]),
          128'(exp_word(v.base, v.count, v.pad, i)));
    end
  endtask

  vec_t        v6;
  logic [79:0] w2;

  initial begin
    tbl[0] = '{"T2", 0, 1, 384, 0, 0, 0, 0, 48};
    tbl[1] = '{"T3", 0, 1, 384, 5, 0, 0, 0, 48};
    tbl[2] = '{"T4", 1, 100, 20, 0, 0, 0, 1023, 3};
    tbl[3] = '{"T5", 0, 1, 384, 0, 1, 100, 0, 48};

    #2 rst_n = 1'b0;
    #1;
    chk("T1_wr_en", 128'(wr_a), 128'(0));
    chk("T1_addr", 128'(addr_a), 128'(0));
    chk("T1_data", 128'(data_a), 128'(0));
    chk("T1_start", 128'(st_a), 128'(0));
    chk("T1_busy", 128'(busy_a), 128'(0));
    chk("T1_done", 128'(done_a), 128'(0));
    chk("T1_ready", 128'(ifa.s_pos_ready), 128'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("T1_busy_rel", 128'(busy_a), 128'(0));
    chk("T1_ready_rel", 128'(ifa.s_pos_ready), 128'(0));
    chk("T1_b_busy_rel", 128'(busy_b), 128'(0));

    for (int t = 0; t < 4; t++) begin
      run_session(tbl[t]);
      if (t == 2) begin
        w2 = log_data[last_w0 + 2];
        chk("T4_w2_lane0", 128'(w2[9:0]), 128'(116));
        chk("T4_w2_lane3", 128'(w2[39:30]), 128'(119));
        chk("T4_w2_lane4", 128'(w2[49:40]), 128'(1023));
        chk("T4_w2_lane7", 128'(w2[79:70]), 128'(1023));
      end
    end

    sel = 1'b0;
    step();
    tload = 1'b1;
    step();
    tload = 1'b0;
    send(1, 13, 0, 0);
    tv = 1'b1;
    tdata = 10'd14;
    #3 rst_n = 1'b0;
    #1;
    chk("T6_ready", 128'(ifa.s_pos_ready), 128'(0));
    chk("T6_wr_en", 128'(wr_a), 128'(0));
    chk("T6_busy", 128'(busy_a), 128'(0));
    chk("T6_start", 128'(st_a), 128'(0));
    tv = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    v6 = tbl[0];
    v6.name = "T6";
    run_session(v6);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
